alu_operand_sequencer: RTL

Upstream and downstream wrapper stage for the combinational ALU on the lab board. It collects operand A, operand B and the 4-bit operation select one at a time from shared switches using a load button. It then presents them as stable registers to the ALU inputs, waits for the ALU to settle, and latches ALU_Out and the Z/N/V/C flags for display. It also detects divide/modulo by zero and unsupported opcodes before issue.

---
 rtl/alu_pkg.sv | 23 ++
 rtl/btn_sync_edge.sv | 23 ++
 rtl/alu_operand_sequencer.sv | 106 ++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: opcode encodings and sequencer state type shared by the ALU wrapper stage
package alu_pkg;
  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_MUL = 4'b0010;
  localparam logic [3:0] OP_DIV = 4'b0011;
  localparam logic [3:0] OP_MOD = 4'b0100;
  localparam logic [3:0] OP_AND = 4'b0101;
  localparam logic [3:0] OP_OR  = 4'b0110;
  localparam logic [3:0] OP_XOR = 4'b0111;
  localparam logic [3:0] OP_SHL = 4'b1000;
  localparam logic [3:0] OP_SHR = 4'b1001;
  localparam logic [3:0] OP_MAX = 4'b1001;

  typedef enum logic [2:0] {
    LOAD_A  = 3'd0,
    LOAD_B  = 3'd1,
    LOAD_OP = 3'd2,
    EXEC    = 3'd3,
    CAPTURE = 3'd4,
    SHOW    = 3'd5
  } state_t;
endpackage

// File: rtl/btn_sync_edge.sv
// btn_sync_edge: synchronizes a raw button level and emits one pulse per rising edge
module btn_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_raw,
  output logic pulse
);
  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_sync <= '0;
      r_prev <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], btn_raw};
      r_prev <= r_sync[SYNC_STAGES-1];
    end

  assign pulse = r_sync[SYNC_STAGES-1] & ~r_prev;
endmodule

// File: rtl/alu_operand_sequencer.sv
// alu_operand_sequencer: collects A, B and opcode from shared switches, issues them
// to the external ALU and latches its result and flags for display.
module alu_operand_sequencer
  import alu_pkg::*;
#(
  parameter int N           = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] sw_data,
  input  logic [3:0]   sw_sel,
  input  logic         btn_load,
  input  logic         btn_clear,
  output logic [N-1:0] alu_a,
  output logic [N-1:0] alu_b,
  output logic [3:0]   alu_sel,
  input  logic [N-1:0] alu_out,
  input  logic         alu_z,
  input  logic         alu_n,
  input  logic         alu_v,
  input  logic         alu_c,
  output logic [N-1:0] result_q,
  output logic [3:0]   flags_q,
  output logic         result_valid,
  output logic         err,
  output logic [2:0]   state_q
);
  logic         w_ld;
  logic         w_clr;
  logic         w_bad;
  state_t       r_state;
  logic [N-1:0] r_a;
  logic [N-1:0] r_b;
  logic [3:0]   r_sel;
  logic [N-1:0] r_res;
  logic [3:0]   r_flags;
  logic         r_valid;
  logic         r_err;

  btn_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_ld  (.clk(clk), .rst_n(rst_n), .btn_raw(btn_load),  .pulse(w_ld));
  btn_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_clr (.clk(clk), .rst_n(rst_n), .btn_raw(btn_clear), .pulse(w_clr));

  // Rejected before issue: undefined opcodes and div/mod with a zero divisor
  assign w_bad = (sw_sel > OP_MAX) || (((sw_sel == OP_DIV) || (sw_sel == OP_MOD)) && (r_b == '0));

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_state <= LOAD_A;
      r_a     <= '0;
      r_b     <= '0;
      r_sel   <= 4'b0000;
      r_res   <= '0;
      r_flags <= 4'b0000;
      r_valid <= 1'b0;
      r_err   <= 1'b0;
    end else if (w_clr) begin
      r_state <= LOAD_A;
      r_valid <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        LOAD_A:
          if (w_ld) begin
            r_a     <= sw_data;
            r_state <= LOAD_B;
          end
        LOAD_B:
          if (w_ld) begin
            r_b     <= sw_data;
            r_state <= LOAD_OP;
          end
        LOAD_OP:
          if (w_ld) begin
            if (w_bad) r_err <= 1'b1;
            else begin
              r_sel   <= sw_sel;
              r_err   <= 1'b0;
              r_state <= EXEC;
            end
          end
        EXEC: r_state <= CAPTURE;
        CAPTURE: begin
          r_res   <= alu_out;
          r_flags <= {alu_z, alu_n, alu_v, alu_c};
          r_valid <= 1'b1;
          r_state <= SHOW;
        end
        SHOW:
          if (w_ld) begin
            r_valid <= 1'b0;
            r_state <= LOAD_A;
          end
        default: r_state <= LOAD_A;
      endcase
    end

  assign alu_a        = r_a;
  assign alu_b        = r_b;
  assign alu_sel      = r_sel;
  assign result_q     = r_res;
  assign flags_q      = r_flags;
  assign result_valid = r_valid;
  assign err          = r_err;
  assign state_q      = r_state;
endmodule
